event_tx_scheduler: RTL

//  Queues 64-bit event packets ({code[63:60], payload[59:0]}) from the sensor/stopwatch sender datapath.

---
 rtl/event_tx_scheduler_if.sv | 24 ++
 rtl/event_tx_scheduler.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/event_tx_scheduler_if.sv
// Event-input and UART-TX handshake bundle between the event sender, the scheduler and uart_tx.
interface event_tx_scheduler_if;
    logic        trig;
    logic [63:0] data;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;

    modport master (
        output trig,
        output data,
        output tx_busy,
        input  tx_start,
        input  tx_data
    );

    modport slave (
        input  trig,
        input  data,
        input  tx_busy,
        output tx_start,
        output tx_data
    );
endinterface

// File: rtl/event_tx_scheduler.sv
// Queues 64-bit event packets and serialises each into a SYNC/EVT/payload/CHK byte frame for
// uart_tx, one byte per start/busy handshake.
module event_tx_scheduler #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    event_tx_scheduler_if.slave        bus_io,
    output logic                       busy_o,
    output logic                       fifo_full_o,
    output logic [7:0]                 drop_cnt_o
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned TW = $clog2(ACK_TIMEOUT) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSend,
        StWaitAck,
        StWaitDone,
        StNext
    } state_e;

    // FIFO keeps only the code and the widest payload slice actually transmitted.
    logic [35:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          fifo_full, fifo_empty;
    logic          push, pop, drop_push, drop_inv;
    logic          unused_data;

    state_e        state_q, state_d;
    logic [3:0]    code_q, code_d;
    logic [31:0]   payload_q, payload_d;
    logic [2:0]    n_q, n_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    chk_q, chk_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [7:0]    drop_q, drop_d;
    logic [8:0]    drop_sum;

    logic [3:0]    head_code;
    logic [2:0]    head_len;
    logic          head_valid;
    logic [7:0]    cur_byte;
    logic          idx_is_chk;

    assign unused_data = ^bus_io.data[27:0];

    assign fifo_full  = (count_q == (AW+1)'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = bus_io.trig && !fifo_full;
    assign drop_push  = bus_io.trig && fifo_full;
    assign head_code  = mem_q[rd_ptr_q][35:32];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus_io.data[63:60], bus_io.data[59:28]};
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Payload length decode; unknown codes are popped and counted as drops.
    always_comb begin
        head_valid = 1'b1;
        head_len   = 3'd0;
        case (head_code)
            4'd1, 4'd3:             head_len = 3'd0;
            4'd2, 4'd4, 4'd5, 4'd7: head_len = 3'd4;
            4'd6:                   head_len = 3'd2;
            default:                head_valid = 1'b0;
        endcase
    end

    assign idx_is_chk = (idx_q == n_q - 3'd1);

    // Payload is consumed MSB-first by shifting, so the next payload byte is always [31:24].
    always_comb begin
        if (idx_q == 3'd0) begin
            cur_byte = 8'hA5;
        end else if (idx_q == 3'd1) begin
            cur_byte = {4'h0, code_q};
        end else if (idx_is_chk) begin
            cur_byte = chk_q;
        end else begin
            cur_byte = payload_q[31:24];
        end
    end

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        payload_d  = payload_q;
        n_d        = n_q;
        idx_d      = idx_q;
        chk_d      = chk_q;
        timer_d    = timer_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        pop        = 1'b0;
        drop_inv   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                pop       = 1'b1;
                code_d    = head_code;
                payload_d = mem_q[rd_ptr_q][31:0];
                n_d       = 3'd3 + head_len;
                idx_d     = 3'd0;
                chk_d     = 8'h00;
                if (head_valid) begin
                    state_d = StSend;
                end else begin
                    drop_inv = 1'b1;
                    state_d  = StIdle;
                end
            end
            StSend: begin
                if (!bus_io.tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = cur_byte;
                    timer_d    = '0;
                    if (idx_q != 3'd0 && !idx_is_chk) begin
                        chk_d = chk_q ^ cur_byte;
                    end
                    if (idx_q >= 3'd2 && !idx_is_chk) begin
                        payload_d = {payload_q[23:0], 8'h00};
                    end
                    state_d = StWaitAck;
                end
            end
            StWaitAck: begin
                if (bus_io.tx_busy) begin
                    state_d = StWaitDone;
                end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                    // UART never acknowledged: treat the byte as sent and move on.
                    state_d = StNext;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StWaitDone: begin
                if (!bus_io.tx_busy) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                idx_d   = idx_q + 3'd1;
                state_d = (idx_q + 3'd1 == n_q) ? StIdle : StSend;
            end
            default: state_d = StIdle;
        endcase
    end

    // Overflow drops and invalid-code drops can coincide in one cycle.
    always_comb begin
        drop_sum = {1'b0, drop_q} + 9'(drop_push) + 9'(drop_inv);
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= StIdle;
            code_q     <= 4'h0;
            payload_q  <= 32'h0;
            n_q        <= 3'd0;
            idx_q      <= 3'd0;
            chk_q      <= 8'h00;
            timer_q    <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            drop_q     <= 8'h00;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            code_q     <= code_d;
            payload_q  <= payload_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            chk_q      <= chk_d;
            timer_q    <= timer_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            drop_q     <= drop_d;
        end
    end

    assign bus_io.tx_start = tx_start_q;
    assign bus_io.tx_data  = tx_data_q;
    assign busy_o          = (state_q != StIdle);
    assign fifo_full_o     = fifo_full;
    assign drop_cnt_o      = drop_q;
endmodule
